// File: rtl/cpu_trace_checker.sv
// rtl/cpu_trace_checker.sv - streaming syntax/semantic checker for CPU trace lines
// Semantic error_code checks are built only when CPU_TRACE_CHECKER_SEM_CHECK_EN is defined.
module cpu_trace_checker #(
   parameter int          TIME_DIGITS = 4,
   parameter int          GRF_DIGITS  = 4,
   parameter int          HEX_DIGITS  = 8,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_4fff,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2fff
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  char,
   input  logic [15:0] freq,
   output logic [1:0]  format_type,
   output logic [3:0]  error_code
);
   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_TIME       = 4'd1;
   localparam logic [3:0] S_PC         = 4'd2;
   localparam logic [3:0] S_COLON      = 4'd3;
   localparam logic [3:0] S_SEP        = 4'd4;
   localparam logic [3:0] S_GRF        = 4'd5;
   localparam logic [3:0] S_ADDR       = 4'd6;
   localparam logic [3:0] S_PRE_ARROW  = 4'd7;
   localparam logic [3:0] S_ARROW      = 4'd8;
   localparam logic [3:0] S_POST_ARROW = 4'd9;
   localparam logic [3:0] S_DATA       = 4'd10;
   localparam logic [3:0] S_DONE       = 4'd11;
   localparam logic [3:0] S_ERR        = 4'd12;

   localparam logic [7:0] T_MAX = 8'(TIME_DIGITS);
   localparam logic [7:0] G_MAX = 8'(GRF_DIGITS);
   localparam logic [7:0] H_MAX = 8'(HEX_DIGITS);

   logic [3:0] state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       is_mem, mem_nx;
   logic       is_dec, is_hex;
   logic       clr, t_en, g_en, p_en, a_en, take;

   assign is_dec = (char >= "0") && (char <= "9");
   assign is_hex = is_dec || ((char >= "a") && (char <= "f"));

   // One shared digit counter; it is rezeroed whenever a new counted field begins.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mem_nx   = is_mem;
      clr      = 1'b0;
      t_en     = 1'b0;
      g_en     = 1'b0;
      p_en     = 1'b0;
      a_en     = 1'b0;
      take     = 1'b0;
      if (char == "^") begin
         state_nx = S_TIME;
         cnt_nx   = 8'd0;
         mem_nx   = 1'b0;
         clr      = 1'b1;
      end else begin
         case (state)
            S_TIME: begin
               if (is_dec && cnt < T_MAX) begin
                  cnt_nx = cnt + 8'd1;
                  t_en   = 1'b1;
               end else if (char == "@" && cnt != 8'd0) begin
                  state_nx = S_PC;
                  cnt_nx   = 8'd0;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_PC: begin
               if (is_hex && cnt < H_MAX) begin
                  cnt_nx = cnt + 8'd1;
                  p_en   = 1'b1;
               end else if (char == ":" && cnt == H_MAX) begin
                  state_nx = S_COLON;
                  cnt_nx   = 8'd0;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_COLON, S_SEP: begin
               if (char == " ") begin
                  state_nx = S_SEP;
               end else if (char == "$") begin
                  state_nx = S_GRF;
               end else if (char == "*") begin
                  state_nx = S_ADDR;
                  mem_nx   = 1'b1;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_GRF: begin
               if (is_dec && cnt < G_MAX) begin
                  cnt_nx = cnt + 8'd1;
                  g_en   = 1'b1;
               end else if (char == " " && cnt != 8'd0) begin
                  state_nx = S_PRE_ARROW;
               end else if (char == "<" && cnt != 8'd0) begin
                  state_nx = S_ARROW;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_ADDR: begin
               if (is_hex && cnt < H_MAX) begin
                  cnt_nx = cnt + 8'd1;
                  a_en   = 1'b1;
               end else if (char == " " && cnt == H_MAX) begin
                  state_nx = S_PRE_ARROW;
               end else if (char == "<" && cnt == H_MAX) begin
                  state_nx = S_ARROW;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_PRE_ARROW: begin
               if (char == "<") state_nx = S_ARROW;
               else if (char != " ") state_nx = S_ERR;
            end
            S_ARROW: begin
               state_nx = (char == "=") ? S_POST_ARROW : S_ERR;
            end
            S_POST_ARROW: begin
               if (is_hex) begin
                  state_nx = S_DATA;
                  cnt_nx   = 8'd1;
               end else if (char != " ") begin
                  state_nx = S_ERR;
               end
            end
            S_DATA: begin
               if (is_hex && cnt < H_MAX) begin
                  cnt_nx = cnt + 8'd1;
               end else if (char == "#" && cnt == H_MAX) begin
                  state_nx = S_DONE;
                  take     = 1'b1;
               end else begin
                  state_nx = S_ERR;
               end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= 8'd0;
         is_mem <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         is_mem <= mem_nx;
      end
   end

   assign format_type = (state == S_DONE) ? (is_mem ? 2'd2 : 2'd1) : 2'd0;

`ifdef CPU_TRACE_CHECKER_SEM_CHECK_EN
   localparam int TW  = 4 * TIME_DIGITS;
   localparam int GW  = 4 * GRF_DIGITS;
   localparam int HW  = 4 * HEX_DIGITS;
   localparam int MW  = (TW > 16) ? TW : 16;
   localparam int XW  = (HW > 32) ? HW : 32;
   localparam int GXW = (GW > 8) ? GW : 8;

   logic [TW-1:0] t_val;
   logic [GW-1:0] g_val;
   logic [HW-1:0] p_val, a_val;
   logic [3:0]    nib, sem_err, err_q;
   logic [MW-1:0] t_mask;

   // 'a'..'f' have low nibble 1..6, so +9 maps them onto 10..15.
   assign nib = is_dec ? char[3:0] : char[3:0] + 4'd9;

   always_comb begin
      t_mask     = MW'(freq >> 1) - MW'(1);
      sem_err    = 4'b0000;
      sem_err[0] = (MW'(t_val) & t_mask) != '0;
      sem_err[1] = (XW'(p_val) < XW'(PC_LO)) || (XW'(p_val) > XW'(PC_HI)) || (p_val[1:0] != 2'b00);
      sem_err[2] = is_mem && ((XW'(a_val) > XW'(ADDR_HI)) || (a_val[1:0] != 2'b00));
      sem_err[3] = !is_mem && (GXW'(g_val) > GXW'(31));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_val <= '0;
         g_val <= '0;
         p_val <= '0;
         a_val <= '0;
         err_q <= 4'b0000;
      end else begin
         if (clr) begin
            t_val <= '0;
            g_val <= '0;
            p_val <= '0;
            a_val <= '0;
         end
         if (t_en) t_val <= t_val * TW'(10) + TW'(nib);
         if (g_en) g_val <= g_val * GW'(10) + GW'(nib);
         if (p_en) p_val <= (p_val << 4) | HW'(nib);
         if (a_en) a_val <= (a_val << 4) | HW'(nib);
         if (take) err_q <= sem_err;
      end
   end

   assign error_code = (state == S_DONE) ? err_q : 4'b0000;
`else
   logic unused_sem;
   assign unused_sem = ^{freq, clr, t_en, g_en, p_en, a_en, take};
   assign error_code = 4'b0000;
`endif

endmodule
